cpu_trace_buffer: RTL and testbench
===================================

CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter sample width.
REQ-002 SHALL have parameter OP_W, default 4, opcode sample width.
REQ-003 SHALL have parameter DEPTH, default 16, trace entries; power of two, >= 4.
REQ-004 SHALL have parameter POST, default 4, samples stored after trigger in mode 1; 0 <= POST < DEPTH.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port arm  input  1  one-cycle pulse: clear buffer, start capture.
REQ-008 SHALL have port mode  input  1  0 = fill-and-stop, 1 = circular with trigger; sampled on arm.
REQ-009 SHALL have port trig_en  input  1  enables opcode trigger in mode 1.
REQ-010 SHALL have port trig_op  input  OP_W  opcode value that fires trigger.
REQ-011 SHALL have port smp_valid  input  1  sample strobe, one per executed instruction.
REQ-012 SHALL have port smp_pc  input  PC_W  sampled PC.
REQ-013 SHALL have port smp_op  input  OP_W  sampled opcode.
REQ-014 SHALL have port rd_en  input  1  pop one entry (DONE state only).
REQ-015 SHALL have port rd_data  output  PC_W+OP_W  {pc, opcode}, registered.
REQ-016 SHALL have port rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-017 SHALL have port count  output  $clog2(DEPTH)+1  entries held.
REQ-018 SHALL have ports busy, done, triggered  output  1 each  status flags.

Function
REQ-019 SHALL implement states IDLE, CAPTURE, POST, DONE; busy = CAPTURE|POST, done = DONE.
REQ-020 arm SHALL, in any state, clear write pointer, count, triggered, latch mode and enter CAPTURE next cycle; a same-cycle sample or read is discarded.
REQ-021 In CAPTURE/POST each smp_valid SHALL write {smp_pc, smp_op} at wr_ptr, advance wr_ptr modulo DEPTH, increment count saturating at DEPTH.
REQ-022 Mode 0: the write making count = DEPTH SHALL move to DONE next cycle; later samples are ignored.
REQ-023 Mode 1: CAPTURE SHALL overwrite oldest entry when full (wrap-around, count stays DEPTH).
REQ-024 Mode 1: smp_valid with trig_en and smp_op == trig_op in CAPTURE SHALL store that sample, set triggered, and enter POST (or DONE if POST = 0).
REQ-025 POST SHALL store exactly POST further samples then enter DONE; further opcode matches ignored.
REQ-026 In DONE, rd_en with count > 0 SHALL return the oldest entry on rd_data with rd_valid one cycle later and decrement count; oldest = index 0 if no wrap occurred, else wr_ptr at DONE entry.
REQ-027 rd_en with count = 0, or outside DONE, SHALL be ignored (rd_valid stays 0).
REQ-028 Changes to mode during capture SHALL have no effect; trig_en/trig_op are evaluated live.
REQ-029 IDLE SHALL ignore smp_valid and rd_en.

Reset
REQ-030 reset low SHALL asynchronously force state IDLE, pointers 0, count 0, rd_data 0, rd_valid 0, busy/done/triggered 0.
REQ-031 Trace memory contents SHALL NOT be reset; reset mid-capture discards the trace.

Structure
REQ-032 State encoding and mode constants SHALL live in shared package cpu_trace_pkg.
REQ-033 Storage SHALL be sub-module trace_ram: simple dual-port, one write port, one synchronous read port, DEPTH x (PC_W+OP_W).

Verification (DEPTH=16, POST=4, PC_W=8, OP_W=4)
REQ-034 Mode 0, arm, 20 samples pc=0..19 -> done after 16th, count=16, reads return pc 0..15 in order, 17th rd_en gives no rd_valid.
REQ-035 Mode 1, trig_op=4'b1010, 30 samples pc=0..29, opcode 1010 only at pc=20 -> triggered=1, count=16, reads return pc 9..24.
REQ-036 Mode 1 trigger on 3rd sample (pc=2), POST=4 -> count=7, reads pc 0..6, no wrap.
REQ-037 arm asserted with smp_valid same cycle during CAPTURE -> sample dropped, count=0, state CAPTURE.
REQ-038 reset low mid-POST -> all outputs 0 immediately; rd_en after release yields no rd_valid.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// Shared FSM state and capture-mode encodings for the CPU trace buffer.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef enum logic {
    MODE_FILL = 1'b0,
    MODE_CIRC = 1'b1
  } mode_e;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// Only the read-data register is reset; the array itself holds no reset.
module trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// CPU instruction trace buffer: fill-and-stop or circular capture with an
// opcode trigger and post-trigger window, read back oldest-first when done.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned OP_W  = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned POST  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm,
  input  logic                       mode,
  input  logic                       trig_en,
  input  logic [OP_W-1:0]            trig_op,
  input  logic                       smp_valid,
  input  logic [PC_W-1:0]            smp_pc,
  input  logic [OP_W-1:0]            smp_op,
  input  logic                       rd_en,
  output logic [PC_W+OP_W-1:0]       rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic                       done,
  output logic                       triggered
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = PC_W + OP_W;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_M1   = CW'(DEPTH - 1);
  localparam logic [AW-1:0] POST_LAST = AW'((POST == 0) ? 0 : POST - 1);

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   post_cnt_q, post_cnt_d;
  logic            triggered_q, triggered_d;
  logic            rd_valid_q, rd_valid_d;

  logic            we, re, trig_hit;
  logic [AW-1:0]   rd_addr;

  assign trig_hit = (mode_q == MODE_CIRC) && trig_en && (smp_op == trig_op);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = ST_CAPTURE;
    end else begin
      case (state_q)
        ST_CAPTURE: begin
          if (smp_valid) begin
            if (mode_q == MODE_FILL) begin
              if (count_q == FULL_M1) state_d = ST_DONE;
            end else if (trig_hit) begin
              state_d = (POST == 0) ? ST_DONE : ST_POST;
            end
          end
        end
        ST_POST: begin
          if (smp_valid && (post_cnt_q == POST_LAST)) state_d = ST_DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == ST_CAPTURE) || (state_q == ST_POST);
    done = (state_q == ST_DONE);
    we   = !arm && smp_valid && busy;
    re   = !arm && rd_en && done && (count_q != '0);
  end

  // Oldest entry sits count entries behind wr_ptr; this covers both the
  // unwrapped (index 0) and wrapped (wr_ptr) cases and advances as count drops.
  assign rd_addr = wr_ptr_q - count_q[AW-1:0];

  always_comb begin
    mode_d      = mode_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    post_cnt_d  = post_cnt_q;
    triggered_d = triggered_q;
    rd_valid_d  = re;
    if (arm) begin
      mode_d      = mode_e'(mode);
      wr_ptr_d    = '0;
      count_d     = '0;
      post_cnt_d  = '0;
      triggered_d = 1'b0;
    end else begin
      if (we) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (count_q != FULL) count_d = count_q + CW'(1);
        if ((state_q == ST_CAPTURE) && trig_hit) triggered_d = 1'b1;
        if (state_q == ST_POST) post_cnt_d = post_cnt_q + AW'(1);
      end
      if (re) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q      <= MODE_FILL;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      post_cnt_q  <= '0;
      triggered_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      post_cnt_q  <= post_cnt_d;
      triggered_q <= triggered_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i ({smp_pc, smp_op}),
    .re_i    (re),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign triggered = triggered_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: directed scenarios then random
// traffic, all compared against a queue-based reference model.
module tb_cpu_trace_buffer;

  localparam int PC_W  = 8;
  localparam int OP_W  = 4;
  localparam int DEPTH = 16;
  localparam int POST  = 4;

  localparam int P_IDLE = 0;
  localparam int P_CAP  = 1;
  localparam int P_POST = 2;
  localparam int P_DONE = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              arm = 1'b0;
  logic              mode = 1'b0;
  logic              trig_en = 1'b0;
  logic [OP_W-1:0]   trig_op = '0;
  logic              smp_valid = 1'b0;
  logic [PC_W-1:0]   smp_pc = '0;
  logic [OP_W-1:0]   smp_op = '0;
  logic              rd_en = 1'b0;
  logic [PC_W+OP_W-1:0] rd_data;
  logic              rd_valid;
  logic [4:0]        count;
  logic              busy, done, triggered;

  cpu_trace_buffer #(
    .PC_W  (PC_W),
    .OP_W  (OP_W),
    .DEPTH (DEPTH),
    .POST  (POST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .arm       (arm),
    .mode      (mode),
    .trig_en   (trig_en),
    .trig_op   (trig_op),
    .smp_valid (smp_valid),
    .smp_pc    (smp_pc),
    .smp_op    (smp_op),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .triggered (triggered)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the trace as an ordered list of entries, oldest first.
  logic [PC_W+OP_W-1:0] mq[$];
  int   ph = P_IDLE;
  bit   m_mode = 1'b0;
  bit   m_trig = 1'b0;
  int   post_left = 0;
  bit   exp_rv = 1'b0;
  logic [PC_W+OP_W-1:0] exp_rd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    ph     = P_IDLE;
    m_trig = 1'b0;
    exp_rv = 1'b0;
    exp_rd = '0;
  endtask

  task automatic model_step();
    exp_rv = 1'b0;
    if (arm) begin
      mq.delete();
      m_mode = mode;
      m_trig = 1'b0;
      ph     = P_CAP;
    end else if ((ph == P_CAP || ph == P_POST) && smp_valid) begin
      mq.push_back({smp_pc, smp_op});
      if (mq.size() > DEPTH) void'(mq.pop_front());
      if (ph == P_CAP) begin
        if (!m_mode) begin
          if (mq.size() == DEPTH) ph = P_DONE;
        end else if (trig_en && smp_op == trig_op) begin
          m_trig = 1'b1;
          if (POST == 0) ph = P_DONE;
          else begin
            ph = P_POST;
            post_left = POST;
          end
        end
      end else begin
        post_left--;
        if (post_left == 0) ph = P_DONE;
      end
    end else if (ph == P_DONE && rd_en && mq.size() > 0) begin
      exp_rv = 1'b1;
      exp_rd = mq.pop_front();
    end
  endtask

  task automatic compare();
    chk("count", 32'(count), 32'(mq.size()));
    chk("busy", 32'(busy), 32'(ph == P_CAP || ph == P_POST));
    chk("done", 32'(done), 32'(ph == P_DONE));
    chk("triggered", 32'(triggered), 32'(m_trig));
    chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
    if (exp_rv) chk("rd_data", 32'(rd_data), 32'(exp_rd));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare();
    arm       = 1'b0;
    smp_valid = 1'b0;
    rd_en     = 1'b0;
  endtask

  task automatic do_arm(input bit md);
    arm  = 1'b1;
    mode = md;
    cyc();
  endtask

  task automatic sample(input int pc, input logic [OP_W-1:0] op);
    smp_valid = 1'b1;
    smp_pc    = PC_W'(pc);
    smp_op    = op;
    cyc();
  endtask

  task automatic read_one();
    rd_en = 1'b1;
    cyc();
  endtask

  initial begin
    model_reset();
    #3;
    compare();
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    #10 reset = 1'b1;

    // Fill-and-stop: 20 samples, only the first 16 kept.
    do_arm(1'b0);
    for (int i = 0; i < 20; i++) sample(i, OP_W'(i));
    chk("m0_done", 32'(done), 32'h1);
    chk("m0_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      read_one();
      chk("m0_rd_pc", 32'(rd_data[PC_W+OP_W-1:OP_W]), 32'(i));
    end
    read_one();
    chk("m0_empty_rd", 32'(rd_valid), 32'h0);

    // Circular with trigger at pc=20 after wrap.
    trig_en = 1'b1;
    trig_op = 4'b1010;
    do_arm(1'b1);
    for (int i = 0; i < 30; i++) sample(i, (i == 20) ? 4'b1010 : 4'b0011);
    chk("m1_trig", 32'(triggered), 32'h1);
    chk("m1_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      read_one();
      chk("m1_rd_pc", 32'(rd_data[PC_W+OP_W-1:OP_W]), 32'(9 + i));
    end

    // Early trigger, no wrap.
    do_arm(1'b1);
    for (int i = 0; i < 10; i++) sample(i, (i == 2) ? 4'b1010 : 4'b0101);
    chk("early_count", 32'(count), 32'd7);
    for (int i = 0; i < 7; i++) begin
      read_one();
      chk("early_rd_pc", 32'(rd_data[PC_W+OP_W-1:OP_W]), 32'(i));
    end

    // Re-arm with a same-cycle sample during capture.
    trig_en = 1'b0;
    do_arm(1'b0);
    for (int i = 0; i < 3; i++) sample(i, 4'h1);
    arm = 1'b1; mode = 1'b0; smp_valid = 1'b1; smp_pc = 8'h55; smp_op = 4'h2;
    cyc();
    chk("rearm_count", 32'(count), 32'd0);
    chk("rearm_busy", 32'(busy), 32'h1);

    // Asynchronous reset in the post-trigger window.
    trig_en = 1'b1;
    do_arm(1'b1);
    sample(1, 4'b1010);
    sample(2, 4'b0101);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare();
    chk("async_rd_data", 32'(rd_data), 32'h0);
    #3 reset = 1'b1;
    read_one();
    chk("post_rst_rd", 32'(rd_valid), 32'h0);

    // Random traffic.
    for (int n = 0; n < 1200; n++) begin
      arm       = ($urandom_range(0, 39) == 0);
      mode      = 1'($urandom);
      trig_en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) trig_op = OP_W'($urandom);
      smp_valid = ($urandom_range(0, 9) < 7);
      smp_pc    = PC_W'($urandom);
      smp_op    = ($urandom_range(0, 9) == 0) ? trig_op : OP_W'($urandom);
      rd_en     = 1'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
